// File: rtl/pkg_ced_stream.sv
// Shared definitions for the frame-to-stream front end: pixel width default,
// marker bit positions inside a FIFO entry, and the sequencer state encoding.
package pkg_ced_stream;

    localparam int PIX_W_DEF = 8;

    // Marker field sits above the pixel in each FIFO entry: {sof, eol, eof}.
    localparam int MK_W   = 3;
    localparam int MK_SOF = 2;
    localparam int MK_EOL = 1;
    localparam int MK_EOF = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO holding {markers, pixel}; push and pop may coincide, in which
// case occupancy is unchanged.
module pix_skid_fifo #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occ       = occ_q;

endmodule

// File: rtl/pixel_stream_source.sv
// Reads a frame from synchronous RAM in raster order and presents it as a
// valid/ready pixel stream with sof/eol/eof markers, one pixel per clock.
module pixel_stream_source import pkg_ced_stream::*; #(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              sof,
    output logic              eol,
    output logic              eof
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int DW   = MK_W + PIX_W;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              inflight_q, inflight_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;

    logic [1:0]        fifo_occ;
    logic [DW-1:0]     head;
    logic [MK_W-1:0]   mk;
    logic [2:0]        credit;
    logic              valid_w, pop, rd_en, last_rd;

    assign valid_w = (fifo_occ != 2'd0);
    assign pop     = valid_w & pix_ready;

    // A read may go out only if its data will find a free slot when it lands:
    // slots already taken or promised, minus the one being freed this cycle.
    always_comb begin
        credit  = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en   = (state_q == ST_FETCH) && (credit < 3'd2);
        last_rd = rd_en && (rd_cnt_q == ADDR_W'(NPIX - 1));
    end

    // Markers are decided from the write-side position of each returning pixel.
    always_comb begin
        mk         = '0;
        mk[MK_SOF] = (col_q == '0) && (row_q == '0);
        mk[MK_EOL] = (col_q == CW'(IMG_W - 1));
        mk[MK_EOF] = mk[MK_EOL] && (row_q == RW'(IMG_H - 1));
    end

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        inflight_d = rd_en;
        col_d      = col_q;
        row_d      = row_q;
        if (rd_en) begin
            rd_cnt_d = last_rd ? '0 : rd_cnt_q + ADDR_W'(1);
        end
        if (inflight_q) begin
            if (mk[MK_EOL]) begin
                col_d = '0;
                row_d = mk[MK_EOF] ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q   <= '0;
            inflight_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            inflight_q <= inflight_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: if (last_rd) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && head[PIX_W + MK_EOF]) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    pix_skid_fifo #(.W(DW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({mk, mem_rd_data}),
        .pop       (pop),
        .head_data (head),
        .occ       (fifo_occ)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rd_en;
    assign mem_addr  = rd_cnt_q;
    assign pix_valid = valid_w;
    assign pix_out   = valid_w ? head[PIX_W-1:0] : '0;
    assign sof       = valid_w & head[PIX_W + MK_SOF];
    assign eol       = valid_w & head[PIX_W + MK_EOL];
    assign eof       = valid_w & head[PIX_W + MK_EOF];

endmodule
